// File: rtl/proc_ctrl_fsm.sv
// Control sequencer for the simple processor datapath: fetch, decode and multi-step execute.
// Optional stall watchdog on the FETCH / MVI handshakes is enabled by defining STALL_TIMEOUT_EN.
module proc_ctrl_fsm #(
  parameter int unsigned REG_SEL_W      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [4+2*REG_SEL_W-1:0]      instr,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [3:0]                    current_state,
  output logic                          ir_load,
  output logic [(2**REG_SEL_W)-1:0]     reg_in,
  output logic [(2**REG_SEL_W)-1:0]     reg_out,
  output logic                          din_out,
  output logic                          a_load,
  output logic                          g_load,
  output logic                          g_out,
  output logic [1:0]                    alu_op,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned NREG = 2 ** REG_SEL_W;
  localparam int unsigned IW   = 4 + 2 * REG_SEL_W;

  localparam logic [3:0] OpMv   = 4'd0;
  localparam logic [3:0] OpMvi  = 4'd1;
  localparam logic [3:0] OpLast = 4'd5;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExec1   = 4'd3,
    StExec2   = 4'd4,
    StExec3   = 4'd5,
    StDone    = 4'd6,
    StError   = 4'd7,
    StWaitClr = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            err_q, err_d;

  logic [3:0]           op;
  logic [REG_SEL_W-1:0] rx;
  logic [REG_SEL_W-1:0] ry;
  logic [NREG-1:0]      rx_oh;
  logic [NREG-1:0]      ry_oh;
  logic                 stall_expired;

  assign op = ir_q[IW-1 -: 4];
  assign rx = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
  assign ry = ir_q[REG_SEL_W-1:0];

  assign rx_oh = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_oh = {{(NREG-1){1'b0}}, 1'b1} << ry;

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             stall;

  assign stall = ((state_q == StFetch) && !instr_valid) ||
                 ((state_q == StExec1) && (op == OpMvi) && !din_valid);

  // The current stall cycle is the TIMEOUT_CYCLES-th one when the count shows one less.
  assign stall_expired = stall && (wdog_q == WdogLast);

  always_comb begin
    wdog_d = '0;
    if (stall && !stall_expired) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  // Stalls are unbounded; TIMEOUT_CYCLES only matters with the watchdog built in.
  assign stall_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    err_d       = err_q;
    instr_ready = 1'b0;
    din_ready   = 1'b0;
    ir_load     = 1'b0;
    reg_in      = '0;
    reg_out     = '0;
    din_out     = 1'b0;
    a_load      = 1'b0;
    g_load      = 1'b0;
    g_out       = 1'b0;
    alu_op      = 2'b00;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          err_d   = 1'b0;
        end
      end

      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_load = 1'b1;
          ir_d    = instr;
          state_d = StDecode;
        end else if (stall_expired) begin
          state_d = StError;
        end
      end

      StDecode: begin
        state_d = (op <= OpLast) ? StExec1 : StError;
      end

      StExec1: begin
        if (op == OpMv) begin
          reg_out = ry_oh;
          reg_in  = rx_oh;
          state_d = StDone;
        end else if (op == OpMvi) begin
          din_ready = 1'b1;
          if (din_valid) begin
            din_out = 1'b1;
            reg_in  = rx_oh;
            state_d = StDone;
          end else if (stall_expired) begin
            state_d = StError;
          end
        end else begin
          reg_out = rx_oh;
          a_load  = 1'b1;
          state_d = StExec2;
        end
      end

      StExec2: begin
        reg_out = ry_oh;
        g_load  = 1'b1;
        alu_op  = 2'(op - 4'd2);
        state_d = StExec3;
      end

      StExec3: begin
        g_out   = 1'b1;
        reg_in  = rx_oh;
        state_d = StDone;
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      StError: begin
        err_d   = 1'b1;
        state_d = StWaitClr;
      end

      // Holding start here must not retrigger the error path.
      StWaitClr: begin
        if (!start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign current_state = state_q;
  assign busy          = (state_q != StIdle);
  assign err           = err_q;

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
Control sequencer for the simple processor datapath. It fetches an instruction word, decodes it, and steps through execution states, driving register-file, accumulator (A), result (G) and bus-mux enables. It also drives the 4-bit current_state code that the step decoder expands into one-hot step selects (codes 0..8 in use). It handshakes with the instruction source and the immediate-data source.

Parameters:
REG_SEL_W, 2, width of each register field in the instruction; NREG = 2**REG_SEL_W registers
TIMEOUT_CYCLES, 16, wait-cycle limit for the optional stall watchdog (only used when STALL_TIMEOUT_EN is defined)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin one instruction; sampled in IDLE only
instr  input  4+2*REG_SEL_W  instruction: [MSB:MSB-3]=opcode, then rx field, then ry field (LSBs)
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  high in FETCH
din_valid  input  1  immediate data is present on the datapath DIN bus
din_ready  output  1  high in EXEC1 of MVI
current_state  output  4  encoded state, to the step decoder
ir_load  output  1  instruction register capture strobe
reg_in  output  NREG  one-hot register write enable
reg_out  output  NREG  one-hot register bus drive
din_out  output  1  DIN drives the bus
a_load  output  1  load A from the bus
g_load  output  1  load G from the ALU
g_out  output  1  G drives the bus
alu_op  output  2  00 add, 01 sub, 10 and, 11 or
busy  output  1  state != IDLE
done  output  1  one-cycle pulse in DONE
err  output  1  sticky illegal-op/timeout flag

Behaviour:
- State encoding (current_state): IDLE=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4, EXEC3=5, DONE=6, ERROR=7, WAIT_CLR=8. Codes 9..15 are never produced.
- Reset: state=IDLE, IR=0, err=0, watchdog=0. After the reset edge, every output is 0 except instr_ready=0 and current_state=0.
- State is registered. All control outputs are decoded combinationally from the state register plus IR; no output is registered beyond the state.
- Transitions:
  - IDLE: if start, go to FETCH. Starting clears err.
  - FETCH: instr_ready=1. Stay until instr_valid. On instr_valid, ir_load=1 in the same cycle, IR<=instr, next state DECODE.
  - DECODE: no controls asserted. Opcodes 0..5 go to EXEC1; opcodes 6..15 go to ERROR.
  - MV (op 0): EXEC1 asserts reg_out[ry] and reg_in[rx], then goes to DONE.
  - MVI (op 1): EXEC1 asserts din_ready. It stalls until din_valid; in that cycle it asserts din_out and reg_in[rx], then goes to DONE.
  - ADD/SUB/AND/OR (ops 2..5): EXEC1 asserts reg_out[rx] and a_load. EXEC2 asserts reg_out[ry], g_load, and alu_op = op-2. EXEC3 asserts g_out and reg_in[rx], then goes to DONE.
  - DONE: done=1, then IDLE. start is ignored in DONE; a held start begins the next instruction from IDLE.
  - ERROR: set err=1, then go to WAIT_CLR.
  - WAIT_CLR: stay while start=1; go to IDLE when start=0. This prevents an error loop on a held start.
- Latency from start accepted to done pulse, with zero-wait handshakes: MV 4 cycles, MVI 4, ALU ops 6.
- rx==ry is legal: for an ALU op the result is written to the same register.
- At most one bit of reg_in and of reg_out is set. Both are all-zero outside the states listed above.
- Reset mid-operation returns to IDLE at the next edge. Partial datapath writes are not undone.

Optional Feature:
STALL_TIMEOUT_EN:
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) counts consecutive stall cycles in FETCH (instr_valid=0) and in MVI EXEC1 (din_valid=0).
  - The counter clears on leaving the wait state.
  - When the count reaches TIMEOUT_CYCLES, the next state is ERROR instead of staying.
- Not defined: the counter is absent, and stalls are unbounded.

Test Plan:
- Reset with start=1 and instr_valid=1 held → current_state=0, busy=0, all enables 0. After reset is released: FETCH on the next edge.
- MVI r2 with din_valid 3 cycles late → din_ready high for 4 cycles. din_out and reg_in=0100 are high for exactly 1 cycle. done 1 cycle later. current_state sequence 0,1,2,3,3,3,3,6,0.
- ADD r1,r3 (instr=8'b0010_01_11) with zero waits → EXEC1: reg_out=0010, a_load. EXEC2: reg_out=1000, g_load, alu_op=00. EXEC3: g_out, reg_in=0010. done on the 6th cycle after start.
- Opcode 4'b1010 with start held high → ERROR then WAIT_CLR. err=1 and stays 1. State stays 8 until start drops, then 0. Next start clears err.
- Reset asserted in EXEC2 of SUB → state 0 after the edge. g_load=0 and done never pulses.
- With STALL_TIMEOUT_EN and TIMEOUT_CYCLES=16: hold instr_valid=0 in FETCH → ERROR after 16 stall cycles, err=1. Without the macro: still in FETCH after 100 cycles.
